ibex_avalon_instr_bridge: RTL and testbench

IBEX_AVALON_INSTR_BRIDGE -- requirements
Module: ibex_avalon_instr_bridge

---
 rtl/ibex_avalon_instr_bridge.sv | 147 ++++++++++++++
 tb/tb_ibex_avalon_instr_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ibex_avalon_instr_bridge.sv
// ibex_avalon_instr_bridge
//   Bridges the Ibex instruction-fetch port to a single-beat Avalon-MM read
//   master. One fetch is outstanding at a time. Fetches outside the
//   MEM_START/MEM_MASK window are answered with an error and issue no bus
//   command. A fetch whose read data never arrives is answered with an error
//   after TIMEOUT_CYCLES, and the late data beat is discarded when it shows up.
//
// Ports
//   IO_CLK, IO_RST_N        clock (rising edge), asynchronous active-low reset
//   instr_req_i/addr_i      core fetch request and byte address
//   instr_gnt_o             request accepted (combinational)
//   instr_rvalid_o/rdata_o  registered one-cycle response and fetched word
//   instr_err_o             response error, qualified by instr_rvalid_o
//   av_read_o/address_o     Avalon read command and word address
//   av_burstcount_o         always 1
//   av_waitrequest_i        slave stall
//   av_readdata_i/valid_i   slave read data and its valid strobe
module ibex_avalon_instr_bridge #(
    parameter logic [31:0] MEM_START      = 32'h0000_0000,
    parameter logic [31:0] MEM_MASK       = 32'h0000_FFFF,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter bit          SWAP_BYTES     = 1'b1
) (
    input  logic        IO_CLK,
    input  logic        IO_RST_N,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        av_read_o,
    output logic [31:0] av_address_o,
    output logic        av_burstcount_o,
    input  logic        av_waitrequest_i,
    input  logic [31:0] av_readdata_i,
    input  logic        av_readdatavalid_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              drop_q;
    logic              av_read_q;
    logic [31:0]       av_address_q;
    logic              rvalid_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic              in_range;
    logic [31:0]       rdata_sw;

    assign in_range = (instr_addr_i & ~MEM_MASK) == MEM_START;

    always_comb begin
        rdata_sw = av_readdata_i;
        if (SWAP_BYTES) begin
            for (int unsigned i = 0; i < 4; i++) begin
                rdata_sw[8*i +: 8] = av_readdata_i[24-8*i +: 8];
            end
        end
    end

    // Grant is the only combinational output: it must track waitrequest
    // within the same cycle so the core sees acceptance exactly when the
    // slave takes the command.
    assign instr_gnt_o     = ((state_q == ST_ADDR) && !av_waitrequest_i) || (state_q == ST_ERR);
    assign instr_rvalid_o  = rvalid_q;
    assign instr_rdata_o   = rdata_q;
    assign instr_err_o     = err_q;
    assign av_read_o       = av_read_q;
    assign av_address_o    = av_address_q;
    assign av_burstcount_o = 1'b1;

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            drop_q       <= 1'b0;
            av_read_q    <= 1'b0;
            av_address_q <= '0;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;

            // A timed-out read's data beat is swallowed here; drop_q can only
            // be set while no new read is in flight, so this beat belongs to it.
            if (drop_q && av_readdatavalid_i) begin
                drop_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (instr_req_i) begin
                        if (!in_range) begin
                            state_q <= ST_ERR;
                        end else if (!drop_q) begin
                            av_address_q <= (instr_addr_i & MEM_MASK) >> 2;
                            av_read_q    <= 1'b1;
                            state_q      <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (!av_waitrequest_i) begin
                        av_read_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (av_readdatavalid_i) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= rdata_sw;
                        state_q  <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        rvalid_q <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                        drop_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    rvalid_q <= 1'b1;
                    err_q    <= 1'b1;
                    rdata_q  <= '0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_avalon_instr_bridge.sv
module tb_ibex_avalon_instr_bridge;

    localparam logic [31:0] START   = 32'h0000_0000;
    localparam logic [31:0] MASK    = 32'h0000_FFFF;
    localparam int          TMO     = 4;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        av_read;
    logic [31:0] av_address;
    logic        av_burst;
    logic        av_wait;
    logic [31:0] av_rdata;
    logic        av_rdv;

    int n_checks = 0;
    int n_fail   = 0;

    ibex_avalon_instr_bridge #(
        .MEM_START      (START),
        .MEM_MASK       (MASK),
        .TIMEOUT_CYCLES (TMO),
        .SWAP_BYTES     (1'b1)
    ) dut (
        .IO_CLK             (clk),
        .IO_RST_N           (rst_n),
        .instr_req_i        (req),
        .instr_addr_i       (addr),
        .instr_gnt_o        (gnt),
        .instr_rvalid_o     (rvalid),
        .instr_rdata_o      (rdata),
        .instr_err_o        (err),
        .av_read_o          (av_read),
        .av_address_o       (av_address),
        .av_burstcount_o    (av_burst),
        .av_waitrequest_i   (av_wait),
        .av_readdata_i      (av_rdata),
        .av_readdatavalid_i (av_rdv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Registered outputs are settled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] byteswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic bit fetchable(input logic [31:0] a);
        return (a & ~MASK) == START;
    endfunction

    // One complete fetch. w = waitrequest cycles, l = DATA-phase cycle index
    // at which read data arrives (l >= TMO means it arrives too late).
    task automatic fetch(input logic [31:0] a, input int w, input int l, input logic [31:0] d);
        bool_block: begin
            req = 1'b1; addr = a; av_wait = 1'b1; av_rdv = 1'b0;
            #1;
            check("idle_gnt", {31'b0, gnt}, 32'd0);
            check("idle_read", {31'b0, av_read}, 32'd0);
            cyc();
            if (!fetchable(a)) begin
                #1;
                check("err_gnt", {31'b0, gnt}, 32'd1);
                check("err_noread", {31'b0, av_read}, 32'd0);
                check("err_rvalid_early", {31'b0, rvalid}, 32'd0);
                cyc();
                req = 1'b0;
                check("err_rvalid", {31'b0, rvalid}, 32'd1);
                check("err_err", {31'b0, err}, 32'd1);
                check("err_rdata", rdata, 32'd0);
                cyc();
                check("err_rvalid_pulse", {31'b0, rvalid}, 32'd0);
                disable bool_block;
            end
            for (int i = 0; i <= w; i++) begin
                if (i > 0) cyc();
                av_wait = (i < w);
                #1;
                check("addr_read", {31'b0, av_read}, 32'd1);
                check("addr_word", av_address, (a & MASK) >> 2);
                check("addr_gnt", {31'b0, gnt}, {31'b0, i == w});
                check("addr_rvalid", {31'b0, rvalid}, 32'd0);
            end
            cyc();
            req = 1'b0; av_wait = 1'b1;
            for (int dc = 0; dc < TMO; dc++) begin
                if (dc > 0) cyc();
                av_rdv = (dc == l); av_rdata = d;
                #1;
                check("data_rvalid", {31'b0, rvalid}, 32'd0);
                check("data_read", {31'b0, av_read}, 32'd0);
                check("data_gnt", {31'b0, gnt}, 32'd0);
                if (dc == l) break;
            end
            cyc();
            av_rdv = 1'b0;
            check("rsp_rvalid", {31'b0, rvalid}, 32'd1);
            if (l < TMO) begin
                check("rsp_err", {31'b0, err}, 32'd0);
                check("rsp_rdata", rdata, byteswap(d));
            end else begin
                check("tmo_err", {31'b0, err}, 32'd1);
                check("tmo_rdata", rdata, 32'd0);
                // Late beat outstanding: an in-range request must wait for it.
                req = 1'b1; addr = a & MASK;
                for (int k = 0; k < 2; k++) begin
                    cyc();
                    #1;
                    check("drop_block_gnt", {31'b0, gnt}, 32'd0);
                    check("drop_block_read", {31'b0, av_read}, 32'd0);
                end
                req = 1'b0; av_rdv = 1'b1; av_rdata = ~d;
                cyc();
                av_rdv = 1'b0;
                check("late_discard", {31'b0, rvalid}, 32'd0);
            end
            cyc();
            check("rsp_pulse", {31'b0, rvalid}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ra;
        rst_n = 1'b0; req = 1'b0; addr = '0; av_wait = 1'b0; av_rdata = '0; av_rdv = 1'b0;
        #12;
        check("rst_gnt", {31'b0, gnt}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_read", {31'b0, av_read}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr", av_address, 32'd0);
        check("burst", {31'b0, av_burst}, 32'd1);
        rst_n = 1'b1;
        cyc();

        fetch(32'h0000_0080, 0, 1, 32'h1122_3344);
        fetch(32'h0000_1234, 5, 0, 32'hDEAD_BEEF);
        fetch(32'h0001_0000, 0, 0, 32'h0);
        fetch(32'h0000_0100, 0, 10, 32'hCAFE_F00D);
        fetch(32'h0000_0104, 1, TMO - 1, 32'h0102_0304);
        fetch(32'h0000_FFFC, 0, 0, 32'hA5A5_5A5A);

        // Stray read data while idle with nothing dropped is ignored.
        av_rdv = 1'b1; av_rdata = 32'h1234_5678;
        cyc();
        av_rdv = 1'b0;
        check("stray_idle", {31'b0, rvalid}, 32'd0);

        for (int t = 0; t < 40; t++) begin
            r = $urandom;
            if ($urandom_range(3) == 0) begin
                ra = r;
                if (fetchable(ra)) ra[31] = 1'b1;
            end else begin
                ra = r & MASK;
            end
            fetch(ra, $urandom_range(3), $urandom_range(TMO + 2), $urandom);
        end

        // Reset while waiting for read data abandons the fetch.
        req = 1'b1; addr = 32'h0000_0040; av_wait = 1'b0;
        cyc();
        cyc();
        req = 1'b0;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("mid_rst_gnt", {31'b0, gnt}, 32'd0);
        check("mid_rst_read", {31'b0, av_read}, 32'd0);
        check("mid_rst_addr", av_address, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_err", {31'b0, err}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        av_rdv = 1'b1; av_rdata = 32'h0BAD_0BAD;
        cyc();
        av_rdv = 1'b0;
        check("post_rst_stray", {31'b0, rvalid}, 32'd0);
        fetch(32'h0000_0200, 2, 1, 32'h89AB_CDEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
